sram_like_slave: RTL and testbench



---
 rtl/sram_like_slave_pkg.sv | 18 +
 rtl/sram_like_slave_be_gen.sv | 23 ++
 rtl/sram_like_slave.sv | 101 ++++++++++
 tb/tb_sram_like_slave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_slave_pkg.sv
// Shared definitions for the sram-like memory responder and its byte-enable decoder.
package sram_like_slave_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // One latched request: everything needed to finish the access later
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/sram_like_slave_be_gen.sv
// Decodes size + low address bits into per-lane byte enables and a misaligned flag.
module sram_like_be_gen
  import sram_like_slave_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addrLo,
  output logic [3:0] be,
  output logic       misaligned
);
  // Size 3 falls into the word branch together with size 2
  always_comb begin
    be         = 4'b1111;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: be = 4'b0001 << addrLo;
      SZ_HALF: begin
        be         = addrLo[1] ? 4'b1100 : 4'b0011;
        misaligned = addrLo[0];
      end
      default: misaligned = (addrLo != 2'b00);
    endcase
  end
endmodule

// File: rtl/sram_like_slave.sv
// Memory-side responder for the core's sram-like port: one outstanding request,
// completed LATENCY wait cycles after acceptance.
// Optional: define SRAM_LIKE_SLAVE_RAND_DELAY_EN to add 0..3 LFSR-chosen extra
// wait cycles per request.
module sram_like_slave
  import sram_like_slave_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      lat;
  req_t                  held;
  req_t                  cur;
  logic                  accept;
  logic                  goResp;
  logic [3:0]            be;
  logic                  misaligned;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unusedAddrBits;
  logic [31:0]           mem [2**DEPTH_LOG2];

`ifdef SRAM_LIKE_SLAVE_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  assign lat = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
  assign lat = CNT_W'(LATENCY);
`endif

  // Accept only in IDLE/RESP; rst gating keeps addr_ok low while held in reset
  assign addr_ok = req & ~rst & (state != WAIT);
  assign accept  = addr_ok;

  // A zero-latency acceptance completes on this edge, so it uses the live inputs
  assign cur    = accept ? {wr, size, addr, wdata} : held;
  assign goResp = (accept && lat == '0) || (state == WAIT && cnt == CNT_W'(1));
  assign idx    = cur.addr[DEPTH_LOG2+1:2];

  assign unusedAddrBits = &{1'b0, cur.addr[31:DEPTH_LOG2+2]};

  sram_like_be_gen uBeGen (
    .size       (cur.size),
    .addrLo     (cur.addr[1:0]),
    .be         (be),
    .misaligned (misaligned)
  );

  // Request FSM: latch on acceptance, count down in WAIT, pulse data_ok in RESP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      held    <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      data_ok <= goResp;
      if (accept) begin
        held <= cur;
        cnt  <= lat;
      end else if (state == WAIT && cnt != CNT_W'(1)) begin
        cnt <= cnt - CNT_W'(1);
      end
      case (state)
        IDLE, RESP: state <= accept ? ((lat == '0) ? RESP : WAIT) : IDLE;
        WAIT:       if (cnt == CNT_W'(1)) state <= RESP;
        default:    state <= IDLE;
      endcase
      if (goResp) begin
        err   <= misaligned;
        rdata <= (cur.wr || misaligned) ? '0 : mem[idx];
      end
    end

  // Byte-lane write on the edge entering RESP; misaligned writes are dropped
  always_ff @(posedge clk)
    if (goResp && cur.wr && !misaligned)
      for (int lane = 0; lane < 4; lane++)
        if (be[lane]) mem[idx][8*lane +: 8] <= cur.wdata[8*lane +: 8];
endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave: dutA runs LATENCY=2, dutB LATENCY=0.
// Expected responses are queued at acceptance and checked when data_ok fires.
module tb_sram_like_slave;
  import sram_like_slave_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  typedef struct {
    logic [31:0] r;
    logic        e;
    int          acc;
  } exp_t;

  logic        clk, rst;
  logic        reqA, reqB, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addrOkA, dataOkA, errA, addrOkB, dataOkB, errB;
  logic [31:0] rdataA, rdataB;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hist [4];
  exp_t sbA[$];
  exp_t sbB[$];

  sram_like_slave #(.DEPTH_LOG2(10), .LATENCY(LAT_A), .CNT_W(5)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addrOkA), .data_ok(dataOkA), .rdata(rdataA), .err(errA));

  sram_like_slave #(.DEPTH_LOG2(10), .LATENCY(LAT_B), .CNT_W(5)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addrOkB), .data_ok(dataOkB), .rdata(rdataB), .err(errB));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic logic aok(input int d);
    return (d == 0) ? addrOkA : addrOkB;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? sbA.size() : sbB.size();
  endfunction

  task automatic setIn(input int d, input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] dt);
    if (d == 0) reqA = r; else reqB = r;
    wr = w; size = sz; addr = a; wdata = dt;
  endtask

  task automatic push(input int d, input logic [31:0] r, input logic e);
    exp_t x;
    x.r = r; x.e = e; x.acc = cyc;
    if (d == 0) sbA.push_back(x); else sbB.push_back(x);
  endtask

  // Drive one request, wait (bounded) for acceptance, then scramble the bus
  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] dt, input logic [31:0] expR, input logic expE);
    int n = 0;
    setIn(d, 1'b1, w, sz, a, dt);
    #1;
    while (!aok(d) && n < 40) begin step(); #1; n++; end
    chk(d == 0 ? "acceptA" : "acceptB", 32'(aok(d)), 1);
    push(d, expR, expE);
    step();
    setIn(d, 1'b0, 1'b1, SZ_WORD, 32'hFFFF_FFFC, 32'hBAD0_BAD0);
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (qsize(d) != 0 && n < 40) begin step(); n++; end
    chk(d == 0 ? "drainA" : "drainB", qsize(d), 0);
  endtask

  task automatic popCheck(input int d, input logic [31:0] r, input logic e);
    exp_t x;
    int   lat, base;
    int   qs = qsize(d);
    chk(d == 0 ? "sb_nonemptyA" : "sb_nonemptyB", 32'(qs > 0), 1);
    if (qs == 0) return;
    if (d == 0) x = sbA.pop_front(); else x = sbB.pop_front();
    lat  = cyc - x.acc - 1;
    base = (d == 0) ? LAT_A : LAT_B;
    chk(d == 0 ? "rdataA" : "rdataB", r, x.r);
    chk(d == 0 ? "errA" : "errB", 32'(e), 32'(x.e));
`ifdef SRAM_LIKE_SLAVE_RAND_DELAY_EN
    chk(d == 0 ? "lat_rangeA" : "lat_rangeB", 32'(lat >= base && lat <= base + 3), 1);
    if (d == 0 && lat >= base && lat <= base + 3) hist[lat - base]++;
`else
    chk(d == 0 ? "latencyA" : "latencyB", lat, base);
`endif
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (dataOkA) popCheck(0, rdataA, errA);
    if (dataOkB) popCheck(1, rdataB, errB);
  end

  initial begin
    int n;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    rst = 1'b1; reqA = 1'b1; reqB = 1'b1; wr = 1'b0; size = SZ_WORD; addr = '0; wdata = '0;
    #1;
    chk("rst_addr_okA", 32'(addrOkA), 0);
    chk("rst_addr_okB", 32'(addrOkB), 0);
    chk("rst_data_okA", 32'(dataOkA), 0);
    chk("rst_rdataA", rdataA, 0);
    chk("rst_errA", 32'(errA), 0);
    step(); step();
    reqA = 1'b0; reqB = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Word write/read
    issue(0, 1'b1, SZ_WORD, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0); drain(0);
    issue(0, 1'b0, SZ_WORD, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0); drain(0);

    // Byte lanes
    issue(0, 1'b1, SZ_WORD, 32'h200, 32'h0000_0000, 32'h0, 1'b0); drain(0);
    issue(0, 1'b1, SZ_BYTE, 32'h202, 32'h00AA_0000, 32'h0, 1'b0); drain(0);
    issue(0, 1'b1, SZ_HALF, 32'h200, 32'h0000_1234, 32'h0, 1'b0); drain(0);
    issue(0, 1'b0, SZ_WORD, 32'h200, 32'h0, 32'h00AA_1234, 1'b0); drain(0);

    // Misaligned accesses: flagged, no write
    issue(0, 1'b1, SZ_WORD, 32'h300, 32'h1122_3344, 32'h0, 1'b0); drain(0);
    issue(0, 1'b1, SZ_HALF, 32'h301, 32'hFFFF_FFFF, 32'h0, 1'b1); drain(0);
    issue(0, 1'b1, 2'd3,    32'h302, 32'hFFFF_FFFF, 32'h0, 1'b1); drain(0);
    issue(0, 1'b0, SZ_WORD, 32'h301, 32'h0, 32'h0, 1'b1); drain(0);
    issue(0, 1'b0, SZ_WORD, 32'h300, 32'h0, 32'h1122_3344, 1'b0); drain(0);

    // Reset while in WAIT: write discarded, read accepted right after release
    setIn(0, 1'b1, 1'b1, SZ_WORD, 32'h100, 32'h5555_5555);
    #1;
    n = 0;
    while (!addrOkA && n < 40) begin step(); #1; n++; end
    chk("rst_test_accept", 32'(addrOkA), 1);
    step();
    reqA = 1'b0;
    rst = 1'b1;
    sbA.delete();
    #1;
    chk("rst_mid_data_ok", 32'(dataOkA), 0);
    step(); step();
    rst = 1'b0;
    setIn(0, 1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0);
    #1;
    chk("accept_after_rst", 32'(addrOkA), 1);
    push(0, 32'hDEAD_BEEF, 1'b0);
    step();
    reqA = 1'b0;
    drain(0);

    // Back-to-back reads on the zero-latency instance
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b1, SZ_WORD, 32'h10 + 32'(4 * i), 32'hB000_0000 + 32'(i), 32'h0, 1'b0);
      drain(1);
    end
    for (int i = 0; i < 4; i++) begin
      setIn(1, 1'b1, 1'b0, SZ_WORD, 32'h10 + 32'(4 * i), 32'h0);
      #1;
      n = 0;
      while (!addrOkB && n < 10) begin step(); #1; n++; end
      chk("b2b_accept", 32'(addrOkB), 1);
      push(1, 32'hB000_0000 + 32'(i), 1'b0);
      step();
    end
    reqB = 1'b0;
    drain(1);

`ifdef SRAM_LIKE_SLAVE_RAND_DELAY_EN
    for (int i = 0; i < 64; i++) begin
      issue(0, 1'b0, SZ_WORD, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
      drain(0);
    end
    for (int k = 0; k < 4; k++) chk("lat_value_seen", 32'(hist[k] > 0), 1);
`endif

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
